// File: rtl/byte_source_arbiter.sv
// Two-source byte arbiter: grants src0 (UART RX) or src1 (SPI RX) onto a single
// registered byte output. It provides round-robin burst fairness, forced and priority modes, and per-source byte counts.
module byte_source_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic [1:0] MODE_RR    = 2'b00;
    localparam logic [1:0] MODE_F0    = 2'b01;
    localparam logic [1:0] MODE_F1    = 2'b10;
    localparam logic [1:0] MODE_PRIO0 = 2'b11;

    localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    state_t                 w_other_state;
    logic                   r_sel;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic [BW-1:0]          r_burst;
    logic [BW-1:0]          w_burst_inc;
    logic [1:0]             w_valid;
    logic [1:0]             w_elig;
    logic [1:0]             w_want;
    logic [1:0]             w_accept;
    logic                   w_g;
    logic                   w_space;
    logic [DATA_W-1:0]      w_mux_data;
    logic [1:0][CNT_W-1:0]  w_cnt;

    assign w_valid       = {in1_valid, in0_valid};
    assign w_elig        = {(mode != MODE_F0), (mode != MODE_F1)};
    assign w_want        = w_valid & w_elig;
    assign w_space       = !r_out_valid || out_ready;
    assign w_accept      = {in1_valid & in1_ready, in0_valid & in0_ready};
    assign w_g           = (r_state == S_GRANT1);
    assign w_other_state = w_g ? S_GRANT0 : S_GRANT1;
    assign w_burst_inc   = r_burst + 1'b1;
    // The source mux follows the registered grant, so sel always matches the granted lane.
    assign w_mux_data    = r_sel ? in1_data : in0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_want[0] && w_want[1]) begin
                    w_state_next = (mode == MODE_RR && !r_sel) ? S_GRANT1 : S_GRANT0;
                end else if (w_want[0]) begin
                    w_state_next = S_GRANT0;
                end else if (w_want[1]) begin
                    w_state_next = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (!w_elig[w_g]) begin
                    w_state_next = S_IDLE;
                end else if (mode == MODE_RR && w_accept[w_g] && w_burst_inc == BURST_LIM) begin
                    if (w_valid[~w_g]) begin
                        w_state_next = w_other_state;
                    end
                end else if (mode == MODE_PRIO0 && w_g && w_accept[1] && in0_valid) begin
                    w_state_next = S_GRANT0;
                end else if (!w_valid[w_g]) begin
                    w_state_next = w_want[~w_g] ? w_other_state : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in0_ready = (r_state == S_GRANT0) && w_space;
        in1_ready = (r_state == S_GRANT1) && w_space;
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 1'b0;
        end else if (w_state_next == S_GRANT0) begin
            r_sel <= 1'b0;
        end else if (w_state_next == S_GRANT1) begin
            r_sel <= 1'b1;
        end
    end

    // Burst restarts on any grant change and after reaching the limit, so it stays bounded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst <= '0;
        end else if (w_state_next != r_state) begin
            r_burst <= '0;
        end else if (|w_accept) begin
            r_burst <= (w_burst_inc == BURST_LIM) ? '0 : w_burst_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (|w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_accept[gi] && r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel       = r_sel;
    assign cnt0      = w_cnt[0];
    assign cnt1      = w_cnt[1];

endmodule

// File: tb/tb_byte_source_arbiter.sv
// Directed bench for byte_source_arbiter: a cycle model checked every cycle,
// plus literal expectations on the forwarded byte streams and key states.
module tb_byte_source_arbiter;

    localparam int DW = 8;
    localparam int BM = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          in0_valid = 1'b0;
    logic [DW-1:0] in0_data = '0;
    logic          in1_valid = 1'b0;
    logic [DW-1:0] in1_data = '0;
    logic          out_ready = 1'b0;
    logic          in0_ready, in1_ready, out_valid, sel, busy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] cnt0, cnt1;

    byte_source_arbiter #(.DATA_W(DW), .BURST_MAX(BM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    byte unsigned q0[$];
    byte unsigned q1[$];
    byte unsigned got[$];
    bit acc0, acc1;
    bit model_on = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the output (-1 none), how many bytes this turn, output register, counts.
    typedef struct {
        int       owner;
        bit       sel;
        bit       ov;
        bit [7:0] od;
        int       run;
        int       c0;
        int       c1;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t next_model(mstate_t s);
        mstate_t  n;
        bit       elig[2];
        bit       v[2];
        bit [7:0] d[2];
        bit       acc;
        int       me;
        int       other;
        n = s;
        elig[0] = (mode != 2'b10);
        elig[1] = (mode != 2'b01);
        v[0] = in0_valid;
        v[1] = in1_valid;
        d[0] = in0_data;
        d[1] = in1_data;
        acc = 1'b0;
        me = s.owner;
        other = 1 - s.owner;
        if (me >= 0) acc = v[me] && (!s.ov || out_ready);
        if (acc) begin
            n.ov = 1'b1;
            n.od = d[me];
            n.run = s.run + 1;
            if (me == 0) n.c0 = (s.c0 < CMAX) ? s.c0 + 1 : CMAX;
            else         n.c1 = (s.c1 < CMAX) ? s.c1 + 1 : CMAX;
        end else if (out_ready) begin
            n.ov = 1'b0;
        end
        if (me < 0) begin
            if (elig[0] && v[0] && elig[1] && v[1]) n.owner = (mode == 2'b00) ? (s.sel ? 0 : 1) : 0;
            else if (elig[0] && v[0]) n.owner = 0;
            else if (elig[1] && v[1]) n.owner = 1;
        end else begin
            if (!elig[me]) n.owner = -1;
            else if (mode == 2'b00 && acc && n.run == BM) begin
                if (v[other]) n.owner = other;
            end else if (mode == 2'b11 && me == 1 && acc && v[0]) n.owner = 0;
            else if (!v[me]) n.owner = (elig[other] && v[other]) ? other : -1;
        end
        if (n.owner != s.owner || n.run == BM) n.run = 0;
        if (n.owner >= 0) n.sel = (n.owner == 1);
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) m <= '{owner: -1, sel: 1'b0, ov: 1'b0, od: 8'h00, run: 0, c0: 0, c1: 0};
        else     m <= next_model(m);
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy", busy, m.owner >= 0);
            check("sel", sel, m.sel);
            check("in0_ready", in0_ready, (m.owner == 0) && (!m.ov || out_ready));
            check("in1_ready", in1_ready, (m.owner == 1) && (!m.ov || out_ready));
            check("out_valid", out_valid, m.ov);
            check("out_data", out_data, m.od);
            check("cnt0", cnt0, m.c0);
            check("cnt1", cnt1, m.c1);
        end
        if (!rst && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic drive();
        in0_valid = (q0.size() != 0);
        in0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        in1_valid = (q1.size() != 0);
        in1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic step();
        @(negedge clk);
        acc0 = in0_valid && in0_ready;
        acc1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        drive();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        drive();
        steps(2);
        model_on = 1'b1;
        got.delete();
        rst = 1'b0;
    endtask

    task automatic check_stream(string name, byte unsigned exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, got[i], exp[i]);
    endtask

    initial begin
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);

        // Single source, full throughput
        mode = 2'b00; out_ready = 1'b1;
        q0 = '{8'h11, 8'h22, 8'h33}; drive();
        steps(8);
        check_stream("single", '{8'h11, 8'h22, 8'h33});
        check("single_cnt0", cnt0, 4'd3);

        // Round-robin fairness: IDLE with sel=0 grants src1 first
        do_reset();
        mode = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        drive();
        steps(30);
        check_stream("rr", '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                             8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                             8'hB8, 8'hB9, 8'hA8, 8'hA9});

        // Backpressure holds the output byte and stalls the source
        do_reset();
        mode = 2'b00; out_ready = 1'b0;
        q0 = '{8'hC1, 8'hC2, 8'hC3}; drive();
        steps(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", out_data, 8'hC1);
            check("bp_hold_ready", in0_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in0_ready, 1'b1);
        steps(6);
        check_stream("bp", '{8'hC1, 8'hC2, 8'hC3});

        // Forced src1 with only src0 valid: nothing moves
        do_reset();
        mode = 2'b10; out_ready = 1'b1;
        q0 = '{8'hD0, 8'hD1}; drive();
        for (int i = 0; i < 4; i++) begin
            step();
            check("f1_busy", busy, 1'b0);
            check("f1_ready0", in0_ready, 1'b0);
        end
        check("f1_len", got.size(), 0);

        // Fixed priority: src0 arriving during GRANT1 takes over after the next src1 byte
        do_reset();
        mode = 2'b11; out_ready = 1'b1;
        q1 = '{8'hE0, 8'hE1, 8'hE2, 8'hE3}; drive();
        steps(2);
        q0 = '{8'hF0, 8'hF1}; drive();
        step();
        check("prio_sel", sel, 1'b0);
        steps(8);
        check_stream("prio", '{8'hE0, 8'hE1, 8'hF0, 8'hF1, 8'hE2, 8'hE3});

        // Fixed priority from IDLE with both valid picks src0
        do_reset();
        mode = 2'b11; out_ready = 1'b1;
        q0 = '{8'h71}; q1 = '{8'h81}; drive();
        steps(6);
        check_stream("prio_idle", '{8'h71, 8'h81});

        // Counter saturation
        do_reset();
        mode = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) q1.push_back(8'h40 + 8'(i));
        drive();
        steps(26);
        check("sat_cnt1", cnt1, 4'hF);
        check("sat_len", got.size(), 20);
        if (got.size() == 20) check("sat_last", got[19], 8'h53);

        // Reset mid-burst discards the held byte
        do_reset();
        mode = 2'b00; out_ready = 1'b0;
        q1 = '{8'h61, 8'h62, 8'h63}; drive();
        steps(3);
        check("mid_sel", sel, 1'b1);
        check("mid_out_valid", out_valid, 1'b1);
        check("mid_cnt1", cnt1, 4'd1);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_sel", sel, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cnt1", cnt1, 4'd0);
        q1.delete(); drive();
        rst = 1'b0;
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_source_arbiter.md
Name: byte_source_arbiter

Overview:
Arbitrates two byte-stream requesters (src0 = UART RX path, src1 = SPI RX path) onto one downstream byte consumer. Drives the select line of the existing 8-bit 2:1 source mux and implements valid/ready handshakes on all three sides. Supports configurable burst fairness and per-source byte counters. Sits between the two serial receivers and the shared byte sink in the FPGA top level.

Parameters:
DATA_W, 8, width of a byte lane
BURST_MAX, 4, max consecutive bytes granted to one source in round-robin mode while the other source is waiting (>=1)
CNT_W, 16, width of the per-source saturating byte counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mode  in  2  00 round-robin, 01 force src0, 10 force src1, 11 fixed priority src0
in0_valid  in  1  src0 byte valid
in0_data  in  DATA_W  src0 byte
in0_ready  out  1  src0 byte accepted when high with in0_valid
in1_valid  in  1  src1 byte valid
in1_data  in  DATA_W  src1 byte
in1_ready  out  1  src1 byte accepted when high with in1_valid
out_valid  out  1  output byte valid (registered)
out_data  out  DATA_W  output byte (registered)
out_ready  in  1  downstream accepts when high with out_valid
sel  out  1  mux select, 0 = src0, 1 = src1 (registered grant)
busy  out  1  high in GRANT0/GRANT1
cnt0  out  CNT_W  bytes forwarded from src0, saturating
cnt1  out  CNT_W  bytes forwarded from src1, saturating

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE; out_valid 0; out_data 0; sel 0; busy 0; in0_ready 0; in1_ready 0; burst count 0; cnt0 0; cnt1 0. Reset mid-transfer discards the held output byte.
- Eligibility by mode:
  - mode 00 and 11: both sources eligible.
  - mode 01: only src0 eligible. mode 10: only src1 eligible.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: no byte accepted. If one eligible source is valid, grant it next cycle.
  - IDLE, both valid: mode 00 grants the source opposite to the current sel; mode 11 grants src0.
- Ready: in<g>_ready = (state == GRANT<g>) && (!out_valid || out_ready). The non-granted ready is 0. Ready is combinational from state and output-register occupancy, never from in*_valid.
- Handshake: accept when in<g>_valid && in<g>_ready. Then out_data <= in<g>_data and out_valid <= 1 next cycle (latency 1). Accept-and-drain in the same cycle gives full throughput of 1 byte/clk.
- out_valid clears on out_ready when no new accept happens that cycle. out_data is held stable while out_valid && !out_ready.
- Burst count: increments on each accept and resets to 0 on every grant change.
- Transitions out of GRANTg (evaluated each cycle; any accept in that cycle still completes):
  - Current source becomes ineligible (mode change): go to IDLE.
  - mode 00: after the accept that makes burst count == BURST_MAX, if the other source is valid, go to GRANT(other). Otherwise stay and restart the burst count.
  - mode 11 in GRANT1: after each src1 accept, if in0_valid is high, go to GRANT0.
  - in<g>_valid low: if the other source is eligible and valid, go to GRANT(other); else go to IDLE.
- sel: 0 in GRANT0, 1 in GRANT1. In IDLE, sel holds its last value.
- busy = (state != IDLE).
- Counters: cnt<g> increments on each src<g> accept. It saturates at all-ones and does not wrap.
- Never drops or duplicates a byte. An input byte offered but not accepted is the requester's responsibility to hold.

Test Plan:
- Single source: mode 00, src0 sends 0x11,0x22,0x33 back-to-back, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first accept; sel=0; cnt0=3; in1_ready stays 0.
- Round-robin fairness: mode 00, BURST_MAX=4, both sources continuously valid (src0 0xA0.., src1 0xB0..) -> output alternates 4 src0 bytes, 4 src1 bytes; sel toggles after each 4th accept.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data held constant, in0_ready=0. Release -> the held byte transfers, and the next byte is accepted the same cycle.
- Forced/priority: mode 10 with only src0 valid -> no accepts, busy=0. Switch to mode 11 while in GRANT1 with src0 valid -> src0 granted after the next src1 byte.
- Counter saturation: CNT_W=4, send 20 src1 bytes -> cnt1 stops at 0xF.
- Reset mid-burst: assert rst with out_valid=1 and state GRANT1 -> next cycle out_valid=0, sel=0, state IDLE, counters 0.
